// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, MSB first, valid/ready byte load
// Optional back-to-back frames under one SSEL: SPI_MASTER_BURST_EN
module spi_master #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             SCK,
    output logic             MOSI,
    input  logic             MISO,
    output logic             SSEL
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t           state;
    state_t           state_n;
    logic [7:0]       div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic             phase_end;
    logic             accept;

    assign phase_end = (div_cnt == DIV_LAST);

`ifdef SPI_MASTER_BURST_EN
    // The last TRAIL cycle may chain straight into the next frame's LEAD.
    assign tx_ready = !RST && ((state == IDLE) || ((state == TRAIL) && phase_end));
`else
    assign tx_ready = !RST && (state == IDLE);
`endif

    assign accept = tx_valid && tx_ready;
    // MOSI is always the top of the transmit shifter; cleared outside a frame.
    assign MOSI   = tx_shift[WIDTH-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = LEAD;
            LEAD:    if (phase_end) state_n = SHIFT;
            SHIFT:   if (phase_end && SCK && (bit_cnt == BIT_LAST)) state_n = TRAIL;
            TRAIL:   if (phase_end) state_n = accept ? LEAD : GAP;
            GAP:     if (phase_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            SCK      <= 1'b0;
            SSEL     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            div_cnt  <= (state == IDLE || phase_end) ? 8'd0 : div_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_shift <= tx_data;
                        SSEL     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                LEAD: begin
                    if (phase_end) begin
                        SCK      <= 1'b1;
                        rx_shift <= {rx_shift[WIDTH-2:0], MISO};
                        bit_cnt  <= BW'(1);
                    end
                end
                SHIFT: begin
                    if (phase_end) begin
                        if (SCK) begin
                            SCK <= 1'b0;
                            // The final falling edge leaves MOSI on the LSB through TRAIL.
                            if (bit_cnt != BIT_LAST) begin
                                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            SCK      <= 1'b1;
                            rx_shift <= {rx_shift[WIDTH-2:0], MISO};
                            bit_cnt  <= bit_cnt + BW'(1);
                        end
                    end
                end
                TRAIL: begin
                    if (phase_end) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        if (accept) begin
                            tx_shift <= tx_data;
                        end else begin
                            tx_shift <= '0;
                            SSEL     <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master (H=4 main, H=1 divider instance)
module tb_spi_master;
    localparam int W      = 8;
    localparam int H      = 4;
    localparam int FRAME  = 2 * H * W + H;
    localparam int H1     = 1;
    localparam int FRAME1 = 2 * H1 * W + H1;
`ifdef SPI_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] tx_data, rx_data;
    logic         tx_valid, tx_ready, rx_valid, busy, sck, mosi, miso, ssel;
    logic [W-1:0] tx_data1, rx_data1;
    logic         tx_valid1, tx_ready1, rx_valid1, busy1, sck1, mosi1, ssel1;

    spi_master #(.WIDTH(W), .CLK_DIV(H)) dut (
        .CLK(clk), .RST(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .SCK(sck), .MOSI(mosi),
        .MISO(miso), .SSEL(ssel)
    );

    spi_master #(.WIDTH(W), .CLK_DIV(H1)) dut1 (
        .CLK(clk), .RST(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .SCK(sck1), .MOSI(mosi1),
        .MISO(1'b0), .SSEL(ssel1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit loopback = 1'b0;

    logic [W-1:0] exp_tx_q[$];
    logic [W-1:0] exp_rx_q[$];
    logic [W-1:0] slave_q[$];
    int           acc_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: presents the front byte MSB first, advancing one bit per SCK rise;
    // MISO is junk whenever SCK is high or SSEL is deasserted.
    int           slv_rises = 0;
    logic         slv_sck_prev = 1'b0;
    logic [W-1:0] slv_byte;
    always @(negedge clk) begin
        if (ssel) begin
            slv_rises = 0;
        end else if (sck && !slv_sck_prev) begin
            slv_rises++;
            if (slv_rises == W) begin
                slv_rises = 0;
                if (slave_q.size() > 0) void'(slave_q.pop_front());
            end
        end
        slv_sck_prev = sck;
        slv_byte = (slave_q.size() > 0) ? slave_q[0] : 8'h00;
        if (loopback)        miso = mosi;
        else if (ssel || sck) miso = 1'($urandom);
        else                 miso = slv_byte[W-1-slv_rises];
    end

    // Monitor: pops the scoreboard whenever the DUT shows a result.
    logic         mon_ssel_prev = 1'b1, mon_sck_prev = 1'b0, mon_rxv_prev = 1'b0;
    logic [W-1:0] mosi_sr = '0;
    int bit_n = 0, rises_p = 0, ssel_cnt = 0, last_len = 0;
    int ssel_periods = 0, total_rises = 0, rxv_cnt = 0;
    bit aborted = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            exp_tx_q.delete(); exp_rx_q.delete(); acc_q.delete(); slave_q.delete();
            bit_n = 0;
            aborted = 1'b1;
        end else if (tx_valid && tx_ready) begin
            acc_q.push_back(cyc);
        end
        if (rx_valid) begin
            rxv_cnt++;
            if (mon_rxv_prev) chk("rx_valid_one_cycle", 2, 1);
            if (exp_rx_q.size() == 0) begin
                chk("rx_valid_unexpected", rx_data, 32'hFFFF_FFFF);
            end else begin
                chk("rx_data", rx_data, exp_rx_q.pop_front());
                if (acc_q.size() > 0) chk("accept_to_rx_valid", cyc - acc_q.pop_front(), FRAME + 1);
            end
        end
        if (!ssel && mon_ssel_prev) begin
            ssel_periods++;
            ssel_cnt = 0;
            rises_p = 0;
            aborted = rst;
        end
        if (!ssel) begin
            ssel_cnt++;
            if (sck && !mon_sck_prev) begin
                rises_p++;
                total_rises++;
                mosi_sr = {mosi_sr[W-2:0], mosi};
                bit_n++;
                if (bit_n == W) begin
                    bit_n = 0;
                    if (exp_tx_q.size() == 0) chk("mosi_unexpected_byte", mosi_sr, 32'hFFFF_FFFF);
                    else chk("mosi_bits", mosi_sr, exp_tx_q.pop_front());
                end
            end
        end
        if (ssel && !mon_ssel_prev && !aborted) begin
            last_len = ssel_cnt;
            chk("frame_rises", rises_p % W, 0);
            chk("ssel_low_len", ssel_cnt, (rises_p / W) * FRAME);
        end
        mon_ssel_prev = ssel;
        mon_sck_prev  = sck;
        mon_rxv_prev  = rx_valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [W-1:0] tx, input logic [W-1:0] mi, input bit keep,
                             output int acc);
        int n = 0;
        exp_tx_q.push_back(tx);
        exp_rx_q.push_back(loopback ? tx : mi);
        slave_q.push_back(loopback ? tx : mi);
        tx_data  = tx;
        tx_valid = 1'b1;
        while (!tx_ready && n < 500) begin
            step(1);
            n++;
        end
        if (!tx_ready) chk("accept_timeout", n, 0);
        acc = cyc;
        step(1);
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_rx_q.size() > 0 && n < 3000) begin
            step(1);
            n++;
        end
        if (exp_rx_q.size() > 0) chk("drain_timeout", exp_rx_q.size(), 0);
        step(H + 2);
    endtask

    int t0, t1, t2, p0, r0, c0, n1, got1, mism;
    logic [W-1:0] rxd1;
    logic         pat[32];
    logic         e;

    initial begin
        tx_data = '0; tx_valid = 1'b0; tx_data1 = '0; tx_valid1 = 1'b0;
        step(3);
        chk("reset_sck", sck, 0);
        chk("reset_ssel", ssel, 1);
        chk("reset_mosi", mosi, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_tx_ready", tx_ready, 0);
        rst = 1'b0;
        step(1);
        chk("idle_tx_ready", tx_ready, 1);

        send_byte(8'hA5, 8'h3C, 1'b0, t0);
        drain();

        c0 = rxv_cnt;
        send_byte(8'h11, 8'h5E, 1'b1, t0);
        send_byte(8'h22, 8'hE7, 1'b0, t1);
        chk("handshake_accept_gap", t1 - t0, BURST ? FRAME : FRAME + H + 1);
        drain();
        chk("handshake_rx_count", rxv_cnt - c0, 2);

        loopback = 1'b1;
        send_byte(8'h81, 8'h00, 1'b0, t0);
        drain();
        for (int i = 0; i < 2; i++) begin
            send_byte(8'($urandom), 8'h00, 1'b0, t0);
            drain();
        end
        loopback = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send_byte(8'($urandom), 8'($urandom), 1'b0, t0);
            step($urandom_range(0, 5));
        end
        drain();

        c0 = rxv_cnt;
        send_byte(8'h5A, 8'hC3, 1'b0, t0);
        step(30);
        rst = 1'b1;
        step(1);
        chk("midrst_ssel", ssel, 1);
        chk("midrst_sck", sck, 0);
        chk("midrst_mosi", mosi, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_ready", tx_ready, 0);
        step(2);
        rst = 1'b0;
        #1;
        chk("midrst_tx_ready_after", tx_ready, 1);
        step(FRAME + 10);
        chk("midrst_no_rx_valid", rxv_cnt - c0, 0);

        p0 = ssel_periods; r0 = total_rises; c0 = rxv_cnt;
        send_byte(8'h01, 8'h9A, 1'b1, t0);
        send_byte(8'h02, 8'h4B, 1'b1, t1);
        send_byte(8'h03, 8'hD2, 1'b0, t2);
        drain();
        chk("burst_ssel_periods", ssel_periods - p0, BURST ? 1 : 3);
        chk("burst_sck_rises", total_rises - r0, 3 * W);
        chk("burst_rx_count", rxv_cnt - c0, 3);
        chk("burst_last_ssel_len", last_len, BURST ? 3 * FRAME : FRAME);
        chk("burst_accept_gap", t2 - t1, BURST ? FRAME : FRAME + H + 1);

        tx_data1 = 8'hFF;
        tx_valid1 = 1'b1;
        chk("div1_tx_ready", tx_ready1, 1);
        step(1);
        tx_valid1 = 1'b0;
        n1 = 0; got1 = 0; rxd1 = 8'hAA;
        for (int i = 0; i < 32; i++) pat[i] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!ssel1) begin
                if (n1 < 32) pat[n1] = sck1;
                n1++;
            end
            if (rx_valid1) begin
                got1++;
                rxd1 = rx_data1;
            end
        end
        mism = 0;
        for (int i = 0; i < FRAME1; i++) begin
            e = (i == 0 || i == FRAME1 - 1) ? 1'b0 : 1'(i % 2);
            if (pat[i] !== e) mism++;
        end
        chk("div1_ssel_len", n1, FRAME1);
        chk("div1_sck_pattern_mismatches", mism, 0);
        chk("div1_rx_valid_count", got1, 1);
        chk("div1_rx_data", rxd1, 0);
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
